// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, frames one latched word as start, LSB-first data, optional parity, stop.
// Ports: clk, rst (sync active-high); p_data/data_valid/par_en/par_typ request inputs sampled on accept;
// tx_out registered serial line (idles high); busy high through the frame; tx_done one-cycle pulse after stop.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] data;
  logic pe, pt, wrap, last, tx_n;
  // tx_n is the line level for the state being entered, so tx_out changes on the same edge as state
  always_comb begin
    wrap = cnt == CW'(PRESCALE - 1);
    last = idx == IW'(DATA_WIDTH - 1);
    state_n = state;
    cnt_n = wrap ? '0 : cnt + CW'(1);
    idx_n = idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = data_valid ? START : IDLE;
      end
      START: state_n = wrap ? DATA : START;
      DATA: begin
        idx_n = wrap ? (last ? '0 : idx + IW'(1)) : idx;
        state_n = wrap && last ? (pe ? PARITY : STOP) : DATA;
      end
      PARITY: state_n = wrap ? STOP : PARITY;
      STOP: state_n = wrap ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA ? data[idx_n] :
           state_n == PARITY ? ^data ^ pt : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      pe <= 1'b0;
      pt <= 1'b0;
      tx_out <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      tx_out <= tx_n;
      busy <= state_n != IDLE;
      tx_done <= state == STOP && wrap;
      if (state == IDLE && data_valid) begin
        data <= p_data;
        pe <= par_en;
        pt <= par_typ;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: self-checking bench for uart_tx_core against a frame-level reference model.
module tb_uart_tx_core;
  localparam int PRE = 16;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0, pe = 1'b0, pt = 1'b0;
  logic [7:0] pd = 8'h00;
  logic tx_out, busy, tx_done;
  int total = 0, bad = 0, done_cnt = 0;
  typedef struct {
    logic [7:0] d;
    bit e;
    bit t;
    int len;
    logic p;
  } vec_t;
  vec_t tbl[5];
  uart_tx_core #(.DATA_WIDTH(8), .PRESCALE(PRE)) dut (
    .clk(clk), .rst(rst), .p_data(pd), .data_valid(dv), .par_en(pe), .par_typ(pt),
    .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (tx_done) done_cnt++;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  // Bit k of a frame: start, data LSB first, optional parity (even => total ones even), stop
  function automatic logic model_bit(input logic [7:0] d, input bit e, input bit t, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (e && k == 9) return logic'($countones(d) % 2) ^ t;
    return 1'b1;
  endfunction
  task automatic start(input logic [7:0] d, input bit e, input bit t);
    @(negedge clk);
    pd = d;
    pe = e;
    pt = t;
    dv = 1'b1;
  endtask
  // Walks a frame from the cycle after the accept edge, then checks the tx_done cycle
  task automatic frame(input logic [7:0] d, input bit e, input bit t, input int inj, input bit hold,
                       input logic [7:0] nd, output int blen, output logic par, output logic [7:0] rx);
    int len = (2 + 8 + int'(e)) * PRE;
    int err = 0;
    int k;
    blen = 0;
    par = 1'b0;
    rx = 8'h00;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      k = j / PRE;
      if (tx_out !== model_bit(d, e, t, k)) err++;
      if (busy === 1'b1) blen++;
      if (j % PRE == PRE / 2) begin
        if (k >= 1 && k <= 8) rx[k-1] = tx_out;
        if (e && k == 9) par = tx_out;
      end
      if (j == 0 && !hold) dv = 1'b0;
      if (inj >= 0 && j == inj) begin
        dv = 1'b1;
        pd = ~d;
        pe = ~e;
        pt = ~t;
      end
      if (inj >= 0 && j == inj + 1) dv = 1'b0;
    end
    chk("frame_bits", err, 0);
    @(negedge clk);
    chk("tx_done", int'(tx_done), 1);
    chk("busy_in_done", int'(busy), 0);
    chk("idle_gap_tx", int'(tx_out), 1);
    if (hold) pd = nd;
  endtask
  initial begin
    int blen, d0, cnt;
    logic par;
    logic [7:0] rx, d;
    bit e, t;
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 160, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 176, 1'b0};
    tbl[2] = '{8'hA5, 1'b1, 1'b1, 176, 1'b1};
    tbl[3] = '{8'h07, 1'b1, 1'b0, 176, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 176, 1'b1};
    dv = 1'b1;
    pd = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx_out), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(tx_done), 0);
    end
    rst = 1'b0;
    dv = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) cnt++;
    end
    chk("post_rst_idle", cnt, 0);
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      start(tbl[i].d, tbl[i].e, tbl[i].t);
      frame(tbl[i].d, tbl[i].e, tbl[i].t, -1, 1'b0, 8'h00, blen, par, rx);
      chk("busy_len", blen, tbl[i].len);
      if (tbl[i].e) chk("parity", int'(par), int'(tbl[i].p));
      chk("rx_word", int'(rx), int'(tbl[i].d));
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
    end
    d0 = done_cnt;
    start(8'h3C, 1'b0, 1'b0);
    frame(8'h3C, 1'b0, 1'b0, 50, 1'b0, 8'h00, blen, par, rx);
    chk("ignore_rx", int'(rx), 8'h3C);
    pe = 1'b0;
    pt = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) cnt++;
    end
    chk("not_queued", cnt, 0);
    chk("ignore_done_once", done_cnt - d0, 1);
    start(8'h55, 1'b0, 1'b0);
    frame(8'h55, 1'b0, 1'b0, -1, 1'b1, 8'hAA, blen, par, rx);
    chk("b2b_rx0", int'(rx), 8'h55);
    frame(8'hAA, 1'b0, 1'b0, -1, 1'b0, 8'h00, blen, par, rx);
    chk("b2b_rx1", int'(rx), 8'hAA);
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    start(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    dv = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", int'(tx_out), 1);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    start(8'hC3, 1'b1, 1'b0);
    frame(8'hC3, 1'b1, 1'b0, -1, 1'b0, 8'h00, blen, par, rx);
    chk("clean_rx", int'(rx), 8'hC3);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      start(d, e, t);
      frame(d, e, t, -1, 1'b0, 8'h00, blen, par, rx);
      chk("rnd_len", blen, (2 + 8 + int'(e)) * PRE);
      chk("rnd_rx", int'(rx), int'(d));
      if (e) chk("rnd_par", int'(par), int'(model_bit(d, e, t, 9)));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
